// File: rtl/td4_sequencer.sv
// rtl/td4_sequencer.sv - TD4 fetch/execute sequencer: PC, carry flag, instruction latch, write strobes
// Optional halt-on-self-jump is built when SEQ_HALT_DETECT_EN is defined.

module td4_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic              STEP,
    input  logic [7:0]        ROM_DATA,
    input  logic [3:0]        LOAD_N,
    input  logic [3:0]        ALU_RESULT,
    input  logic              CARRY_IN,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [3:0]        OPERATION,
    output logic [3:0]        IMM,
    output logic              CARRY_FLAG,
    output logic [2:0]        REG_WE,
    output logic              BUSY,
    output logic              HALTED,
    output logic              INSTR_DONE
);

`ifdef SEQ_HALT_DETECT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jump_target;
    logic              step_prev;
    logic              step_edge;

    assign jump_target = ADDR_W'(ALU_RESULT);
    assign step_edge   = STEP & ~step_prev;
    assign ROM_ADDR    = pc;

`ifdef SEQ_HALT_DETECT_EN
    logic halt_hit;
    assign halt_hit = ~LOAD_N[3] && (jump_target == pc);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            pc         <= '0;
            OPERATION  <= 4'd0;
            IMM        <= 4'd0;
            CARRY_FLAG <= 1'b0;
            step_prev  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_prev <= STEP;
            if (state == FETCH) begin
                OPERATION <= ROM_DATA[7:4];
                IMM       <= ROM_DATA[3:0];
            end
            // Carry is refreshed by every instruction, so a conditional jump sees the previous one's carry.
            if (state == EXEC) begin
                CARRY_FLAG <= CARRY_IN;
                pc         <= LOAD_N[3] ? (pc + PC_ONE) : jump_target;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        REG_WE     = 3'b000;
        BUSY       = 1'b0;
        HALTED     = 1'b0;
        INSTR_DONE = 1'b0;
        case (state)
            IDLE: begin
                if (RUN || step_edge) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                BUSY      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                BUSY       = 1'b1;
                INSTR_DONE = 1'b1;
                // A reset arriving mid-instruction must not leak a register write.
                if (!RESET) begin
                    REG_WE = ~LOAD_N[2:0];
                end
`ifdef SEQ_HALT_DETECT_EN
                if (halt_hit) begin
                    state_nxt = HALT;
                end else if (RUN) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = RUN ? FETCH : IDLE;
`endif
            end
`ifdef SEQ_HALT_DETECT_EN
            HALT: begin
                HALTED = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// tb/tb_td4_sequencer.sv - self-checking bench for td4_sequencer with ROM/decoder/ALU environment and instruction-level model

module tb_td4_sequencer;

    logic       CLK;
    logic       RESET;
    logic       RUN;
    logic       STEP;
    logic [7:0] ROM_DATA;
    logic [3:0] LOAD_N;
    logic [3:0] ALU_RESULT;
    logic       CARRY_IN;
    logic [3:0] ROM_ADDR;
    logic [3:0] OPERATION;
    logic [3:0] IMM;
    logic       CARRY_FLAG;
    logic [2:0] REG_WE;
    logic       BUSY;
    logic       HALTED;
    logic       INSTR_DONE;

    int checks = 0;
    int errors = 0;

`ifdef SEQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Environment: ROM, decoder table indexed by {opcode, carry}, adder = imm + per-opcode operand.
    logic [7:0] rom     [16];
    logic [3:0] dec_tab [32];
    logic [3:0] add_tab [16];
    logic [4:0] sum;

    assign ROM_DATA   = rom[ROM_ADDR];
    assign LOAD_N     = dec_tab[{OPERATION, CARRY_FLAG}];
    assign sum        = {1'b0, IMM} + {1'b0, add_tab[OPERATION]};
    assign ALU_RESULT = sum[3:0];
    assign CARRY_IN   = sum[4];

    td4_sequencer #(.ADDR_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
        .ROM_DATA(ROM_DATA), .LOAD_N(LOAD_N), .ALU_RESULT(ALU_RESULT), .CARRY_IN(CARRY_IN),
        .ROM_ADDR(ROM_ADDR), .OPERATION(OPERATION), .IMM(IMM), .CARRY_FLAG(CARRY_FLAG),
        .REG_WE(REG_WE), .BUSY(BUSY), .HALTED(HALTED), .INSTR_DONE(INSTR_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RUN   = 1'b0;
        STEP  = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 16; i++) begin
            rom[i]     = 8'h03;
            add_tab[i] = 4'h0;
        end
        for (int i = 0; i < 32; i++) dec_tab[i] = 4'b1110;
    endtask

    task automatic test_reset();
        fill_plain();
        do_reset();
        checks++;
        if ({ROM_ADDR, OPERATION, IMM, CARRY_FLAG} !== 13'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 0000", {ROM_ADDR, OPERATION, IMM, CARRY_FLAG});
        end
        checks++;
        if ({REG_WE, BUSY, HALTED, INSTR_DONE} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 000000", {REG_WE, BUSY, HALTED, INSTR_DONE});
        end
    endtask

    task automatic test_first_instr();
        fill_plain();
        do_reset();
        RUN = 1'b1;
        tick();
        checks++;
        if ({BUSY, INSTR_DONE, REG_WE, ROM_ADDR} !== {1'b1, 1'b0, 3'b000, 4'd0}) begin
            errors++;
            $display("FAIL first_fetch: got %b expected 1000000000", {BUSY, INSTR_DONE, REG_WE, ROM_ADDR});
        end
        RUN = 1'b0;
        tick();
        checks++;
        if ({INSTR_DONE, REG_WE, OPERATION, IMM} !== {1'b1, 3'b001, 4'h0, 4'h3}) begin
            errors++;
            $display("FAIL first_exec: got %h expected %h", {INSTR_DONE, REG_WE, OPERATION, IMM}, {1'b1, 3'b001, 8'h03});
        end
        tick();
        checks++;
        if ({BUSY, ROM_ADDR} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL first_pc: got busy=%b pc=%0d expected busy=0 pc=1", BUSY, ROM_ADDR);
        end
    endtask

    task automatic test_single_step();
        int dones;
        fill_plain();
        do_reset();
        STEP  = 1'b1;
        dones = 0;
        repeat (10) begin
            tick();
            if (INSTR_DONE) dones++;
        end
        checks++;
        if (dones != 1 || ROM_ADDR !== 4'd1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL step_held: got dones=%0d pc=%0d busy=%b expected 1 1 0", dones, ROM_ADDR, BUSY);
        end
        STEP = 1'b0;
        tick();
        STEP  = 1'b1;
        dones = 0;
        repeat (6) begin
            tick();
            if (INSTR_DONE) dones++;
        end
        checks++;
        if (dones != 1 || ROM_ADDR !== 4'd2 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL step_again: got dones=%0d pc=%0d busy=%b expected 1 2 0", dones, ROM_ADDR, BUSY);
        end
        STEP = 1'b0;
    endtask

    task automatic test_jnc();
        fill_plain();
        rom[0] = 8'hE5;
        rom[5] = 8'h0F;
        rom[6] = 8'hE5;
        dec_tab[{4'hE, 1'b0}] = 4'b0111;
        dec_tab[{4'hE, 1'b1}] = 4'b1111;
        add_tab[4'h0] = 4'h1;
        do_reset();
        RUN = 1'b1;
        tick();
        tick();
        checks++;
        if ({CARRY_FLAG, REG_WE, INSTR_DONE} !== 5'b0_000_1) begin
            errors++;
            $display("FAIL jnc_taken_exec: got %b expected 00001", {CARRY_FLAG, REG_WE, INSTR_DONE});
        end
        tick();
        checks++;
        if (ROM_ADDR !== 4'd5) begin
            errors++;
            $display("FAIL jnc_taken_pc: got %0d expected 5", ROM_ADDR);
        end
        tick();
        tick();
        checks++;
        if ({ROM_ADDR, CARRY_FLAG} !== {4'd6, 1'b1}) begin
            errors++;
            $display("FAIL carry_set: got pc=%0d c=%b expected pc=6 c=1", ROM_ADDR, CARRY_FLAG);
        end
        tick();
        RUN = 1'b0;
        tick();
        checks++;
        if ({BUSY, ROM_ADDR, CARRY_FLAG} !== {1'b0, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL jnc_not_taken: got busy=%b pc=%0d c=%b expected 0 7 0", BUSY, ROM_ADDR, CARRY_FLAG);
        end
    endtask

    task automatic test_wrap_run_drop();
        fill_plain();
        do_reset();
        RUN = 1'b1;
        repeat (31) tick();
        checks++;
        if ({BUSY, INSTR_DONE, ROM_ADDR} !== {1'b1, 1'b0, 4'd15}) begin
            errors++;
            $display("FAIL pc15_fetch: got busy=%b done=%b pc=%0d expected 1 0 15", BUSY, INSTR_DONE, ROM_ADDR);
        end
        RUN = 1'b0;
        tick();
        checks++;
        if ({BUSY, INSTR_DONE} !== 2'b11) begin
            errors++;
            $display("FAIL run_drop_exec: got busy=%b done=%b expected 1 1", BUSY, INSTR_DONE);
        end
        tick();
        checks++;
        if ({BUSY, ROM_ADDR} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL pc_wrap_idle: got busy=%b pc=%0d expected 0 0", BUSY, ROM_ADDR);
        end
    endtask

    task automatic test_self_jump();
        int dones;
        int bad;
        fill_plain();
        rom[7] = 8'hF7;
        dec_tab[{4'hF, 1'b0}] = 4'b0110;
        dec_tab[{4'hF, 1'b1}] = 4'b0110;
        do_reset();
        RUN = 1'b1;
        repeat (16) tick();
        checks++;
        if ({ROM_ADDR, REG_WE, INSTR_DONE} !== {4'd7, 3'b001, 1'b1}) begin
            errors++;
            $display("FAIL self_jump_exec: got pc=%0d we=%b done=%b expected 7 001 1", ROM_ADDR, REG_WE, INSTR_DONE);
        end
        dones = 0;
        bad   = 0;
        if (HALT_EN) begin
            tick();
            checks++;
            if ({HALTED, BUSY, ROM_ADDR} !== {1'b1, 1'b0, 4'd7}) begin
                errors++;
                $display("FAIL halt_enter: got halted=%b busy=%b pc=%0d expected 1 0 7", HALTED, BUSY, ROM_ADDR);
            end
            repeat (20) begin
                tick();
                if (REG_WE !== 3'b000 || INSTR_DONE !== 1'b0 || HALTED !== 1'b1 || ROM_ADDR !== 4'd7) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
            end
            do_reset();
            checks++;
            if ({HALTED, BUSY, ROM_ADDR} !== {1'b0, 1'b0, 4'd0}) begin
                errors++;
                $display("FAIL halt_reset: got halted=%b busy=%b pc=%0d expected 0 0 0", HALTED, BUSY, ROM_ADDR);
            end
        end else begin
            repeat (20) begin
                tick();
                if (INSTR_DONE) dones++;
                if (ROM_ADDR !== 4'd7 || HALTED !== 1'b0) bad++;
            end
            checks++;
            if (dones != 10 || bad != 0) begin
                errors++;
                $display("FAIL self_jump_loop: got dones=%0d bad=%0d expected 10 0", dones, bad);
            end
            RUN = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_reset_in_exec();
        fill_plain();
        do_reset();
        RUN = 1'b1;
        tick();
        tick();
        checks++;
        if (REG_WE !== 3'b001) begin
            errors++;
            $display("FAIL pre_reset_we: got %b expected 001", REG_WE);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (REG_WE !== 3'b000) begin
            errors++;
            $display("FAIL reset_cycle_we: got %b expected 000", REG_WE);
        end
        tick();
        RESET = 1'b0;
        RUN   = 1'b0;
        checks++;
        if ({ROM_ADDR, OPERATION, IMM, CARRY_FLAG, REG_WE, BUSY, HALTED, INSTR_DONE} !== 19'h0) begin
            errors++;
            $display("FAIL reset_after_exec: got %h expected 0",
                     {ROM_ADDR, OPERATION, IMM, CARRY_FLAG, REG_WE, BUSY, HALTED, INSTR_DONE});
        end
    endtask

    // Instruction-level reference: each instruction reads rom[pc], consults the decoder
    // with the carry left by the previous instruction, then jumps or increments.
    task automatic test_random();
        logic [3:0] mpc;
        logic       mc;
        logic [7:0] ibyte;
        logic [3:0] ln;
        logic [4:0] s;
        logic       nrun;
        logic       halted_m;
        for (int run_i = 0; run_i < 6; run_i++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i]     = 8'($urandom);
                add_tab[i] = 4'($urandom);
            end
            for (int i = 0; i < 32; i++) dec_tab[i] = 4'($urandom);
            do_reset();
            mpc      = 4'd0;
            mc       = 1'b0;
            halted_m = 1'b0;
            RUN      = 1'b1;
            for (int n = 0; n < 40 && !halted_m; n++) begin
                tick();
                checks++;
                if ({BUSY, INSTR_DONE, REG_WE, ROM_ADDR} !== {1'b1, 1'b0, 3'b000, mpc}) begin
                    errors++;
                    $display("FAIL rnd_fetch: got %b expected %b", {BUSY, INSTR_DONE, REG_WE, ROM_ADDR},
                             {1'b1, 1'b0, 3'b000, mpc});
                end
                ibyte = rom[mpc];
                ln    = dec_tab[{ibyte[7:4], mc}];
                s     = {1'b0, ibyte[3:0]} + {1'b0, add_tab[ibyte[7:4]]};
                nrun  = ($urandom % 4) != 0;
                RUN   = nrun;
                tick();
                checks++;
                if ({INSTR_DONE, REG_WE, OPERATION, IMM, CARRY_FLAG} !== {1'b1, ~ln[2:0], ibyte, mc}) begin
                    errors++;
                    $display("FAIL rnd_exec: got %h expected %h", {INSTR_DONE, REG_WE, OPERATION, IMM, CARRY_FLAG},
                             {1'b1, ~ln[2:0], ibyte, mc});
                end
                halted_m = HALT_EN && !ln[3] && (s[3:0] == mpc);
                mpc      = ln[3] ? mpc + 4'd1 : s[3:0];
                mc       = s[4];
                if (halted_m) begin
                    tick();
                    checks++;
                    if ({HALTED, BUSY, ROM_ADDR, CARRY_FLAG} !== {1'b1, 1'b0, mpc, mc}) begin
                        errors++;
                        $display("FAIL rnd_halt: got %b expected %b", {HALTED, BUSY, ROM_ADDR, CARRY_FLAG},
                                 {1'b1, 1'b0, mpc, mc});
                    end
                end else if (!nrun) begin
                    tick();
                    checks++;
                    if ({BUSY, HALTED, ROM_ADDR, CARRY_FLAG} !== {1'b0, 1'b0, mpc, mc}) begin
                        errors++;
                        $display("FAIL rnd_idle: got %b expected %b", {BUSY, HALTED, ROM_ADDR, CARRY_FLAG},
                                 {1'b0, 1'b0, mpc, mc});
                    end
                    RUN = 1'b1;
                end
            end
            RUN = 1'b0;
        end
    endtask

    initial begin
        RESET = 1'b1;
        RUN   = 1'b0;
        STEP  = 1'b0;
        fill_plain();
        test_reset();
        test_first_instr();
        test_single_step();
        test_jnc();
        test_wrap_run_drop();
        test_self_jump();
        test_reset_in_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
